// File: rtl/inst_d.sv
// rtl/inst_d.sv - instruction decode stage: IF/ID register, register file, decoder, load-use hazard, ID/EX register
module inst_d #(
    parameter int          XLEN     = 32,
    parameter int          NREG     = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instruction,
    input  logic [31:0]     pc4,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            hazard,
    output logic [31:0]     ex_add,
    output logic            id_ex_valid,
    output logic [XLEN-1:0] id_ex_rs_data,
    output logic [XLEN-1:0] id_ex_rt_data,
    output logic [XLEN-1:0] id_ex_imm,
    output logic [4:0]      id_ex_rs,
    output logic [4:0]      id_ex_rt,
    output logic [4:0]      id_ex_rd,
    output logic [7:0]      id_ex_ctrl,
    output logic [5:0]      id_ex_funct
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [31:0]     r_ifid_instr;
    logic [31:0]     r_ifid_pc4;
    logic            r_ifid_valid;
    logic [XLEN-1:0] r_regs [NREG];

    logic            r_valid;
    logic [XLEN-1:0] r_rs_data;
    logic [XLEN-1:0] r_rt_data;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs;
    logic [4:0]      r_rt;
    logic [4:0]      r_rd;
    logic [7:0]      r_ctrl;
    logic [5:0]      r_funct;
    logic [31:0]     r_ex_add;

    logic [5:0]      w_op;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_ext;
    logic [7:0]      w_ctrl;
    logic [4:0]      w_dest;
    logic            w_uses_rt;
    logic [XLEN-1:0] w_rs_data;
    logic [XLEN-1:0] w_rt_data;
    logic [31:0]     w_target;
    logic            w_hazard;
    logic            w_unused;

    assign w_op      = r_ifid_instr[31:26];
    assign w_rs      = r_ifid_instr[25:21];
    assign w_rt      = r_ifid_instr[20:16];
    assign w_rd      = r_ifid_instr[15:11];
    assign w_imm_ext = {{(XLEN-16){r_ifid_instr[15]}}, r_ifid_instr[15:0]};
    assign w_unused  = ^r_ifid_instr[10:6];

    always_comb begin
        w_ctrl = 8'b0000_0000;
        w_dest = 5'd0;
        case (w_op)
            OP_RTYPE: begin w_ctrl = 8'b1000_0010; w_dest = w_rd; end
            OP_LW:    begin w_ctrl = 8'b1101_0000; w_dest = w_rt; end
            OP_SW:    begin w_ctrl = 8'b0011_0000; end
            OP_BEQ:   begin w_ctrl = 8'b0000_1001; end
            OP_ADDI:  begin w_ctrl = 8'b1001_0000; w_dest = w_rt; end
            OP_J:     begin w_ctrl = 8'b0000_0100; end
            default:  begin w_ctrl = 8'b0000_0000; w_dest = 5'd0; end
        endcase
    end

    // Register file reads bypass the writeback port so decode sees the value retiring this cycle
    always_comb begin
        w_rs_data = '0;
        w_rt_data = '0;
        if (w_rs != 5'd0)
            w_rs_data = (wb_we && wb_addr == w_rs) ? wb_data : r_regs[w_rs];
        if (w_rt != 5'd0)
            w_rt_data = (wb_we && wb_addr == w_rt) ? wb_data : r_regs[w_rt];
    end

    // rt is only a source operand for R-type, beq and sw
    assign w_uses_rt = (w_op == OP_RTYPE) || (w_op == OP_BEQ) || (w_op == OP_SW);
    assign w_hazard  = !rst && r_valid && r_ctrl[6] && (r_rd != 5'd0) && r_ifid_valid &&
                       ((r_rd == w_rs) || ((r_rd == w_rt) && w_uses_rt));

    always_comb begin
        w_target = r_ifid_pc4;
        if (w_op == OP_BEQ)
            w_target = r_ifid_pc4 + {w_imm_ext[29:0], 2'b00};
        else if (w_op == OP_J)
            w_target = {r_ifid_pc4[31:28], r_ifid_instr[25:0], 2'b00};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifid_instr <= NOP_INST;
            r_ifid_pc4   <= 32'd0;
            r_ifid_valid <= 1'b0;
        end else if (flush) begin
            r_ifid_instr <= NOP_INST;
            r_ifid_valid <= 1'b0;
        end else if (!w_hazard) begin
            r_ifid_instr <= instruction;
            r_ifid_pc4   <= pc4;
            r_ifid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (wb_we && wb_addr != 5'd0) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= 5'd0;
            r_rt      <= 5'd0;
            r_rd      <= 5'd0;
            r_ctrl    <= 8'd0;
            r_funct   <= 6'd0;
            r_ex_add  <= 32'd0;
        end else if (flush || w_hazard) begin
            r_valid   <= 1'b0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= 5'd0;
            r_rt      <= 5'd0;
            r_rd      <= 5'd0;
            r_ctrl    <= 8'd0;
            r_funct   <= 6'd0;
        end else begin
            r_valid   <= r_ifid_valid;
            r_rs_data <= w_rs_data;
            r_rt_data <= w_rt_data;
            r_imm     <= w_imm_ext;
            r_rs      <= w_rs;
            r_rt      <= w_rt;
            r_rd      <= w_dest;
            r_ctrl    <= w_ctrl;
            r_funct   <= r_ifid_instr[5:0];
            r_ex_add  <= w_target;
        end
    end

    assign hazard        = w_hazard;
    assign ex_add        = r_ex_add;
    assign id_ex_valid   = r_valid;
    assign id_ex_rs_data = r_rs_data;
    assign id_ex_rt_data = r_rt_data;
    assign id_ex_imm     = r_imm;
    assign id_ex_rs      = r_rs;
    assign id_ex_rt      = r_rt;
    assign id_ex_rd      = r_rd;
    assign id_ex_ctrl    = r_ctrl;
    assign id_ex_funct   = r_funct;

endmodule

// File: tb/tb_inst_d.sv
// tb/tb_inst_d.sv - self-checking bench for inst_d against a behavioural pipeline model
module tb_inst_d;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] pc4;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        hazard;
    logic [31:0] ex_add;
    logic        id_ex_valid;
    logic [31:0] id_ex_rs_data;
    logic [31:0] id_ex_rt_data;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_rs;
    logic [4:0]  id_ex_rt;
    logic [4:0]  id_ex_rd;
    logic [7:0]  id_ex_ctrl;
    logic [5:0]  id_ex_funct;

    int n_checks = 0;
    int n_errors = 0;

    inst_d dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc4(pc4), .flush(flush),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .hazard(hazard),
        .ex_add(ex_add), .id_ex_valid(id_ex_valid), .id_ex_rs_data(id_ex_rs_data),
        .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm), .id_ex_rs(id_ex_rs),
        .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd), .id_ex_ctrl(id_ex_ctrl),
        .id_ex_funct(id_ex_funct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] m_regs [32];
    logic [31:0] m_ifid_instr, m_ifid_pc4;
    logic        m_ifid_valid;
    logic        m_valid;
    logic [31:0] m_rs_data, m_rt_data, m_imm, m_ex_add;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [7:0]  m_ctrl;
    logic [5:0]  m_funct;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ctrl_of(input logic [5:0] op);
        logic rw, mr, mw, as, br, jp;
        logic [1:0] aop;
        {rw, mr, mw, as, br, jp, aop} = 8'd0;
        case (op)
            6'h00: begin rw = 1; aop = 2'b10; end
            6'h23: begin rw = 1; mr = 1; as = 1; end
            6'h2b: begin mw = 1; as = 1; end
            6'h04: begin br = 1; aop = 2'b01; end
            6'h08: begin rw = 1; as = 1; end
            6'h02: begin jp = 1; end
            default: ;
        endcase
        return {rw, mr, mw, as, br, jp, aop};
    endfunction

    function automatic logic [4:0] dest_of(input logic [31:0] ins);
        if (ins[31:26] == 6'h00) return ins[15:11];
        if (ins[31:26] == 6'h23 || ins[31:26] == 6'h08) return ins[20:16];
        return 5'd0;
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'd0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic logic model_hazard();
        logic [5:0] op;
        logic uses_rt;
        op = m_ifid_instr[31:26];
        uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h2b);
        return m_valid && m_ctrl[6] && (m_rd != 0) && m_ifid_valid &&
               ((m_rd == m_ifid_instr[25:21]) || (m_rd == m_ifid_instr[20:16] && uses_rt));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_ifid_instr = 32'd0; m_ifid_pc4 = 32'd0; m_ifid_valid = 0;
        m_valid = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0; m_ex_add = 0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_ctrl = 0; m_funct = 0;
    endtask

    task automatic model_step(input logic [31:0] in_i, input logic [31:0] in_pc4, input logic fl,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic hz;
        logic [31:0] ins;
        ins = m_ifid_instr;
        hz  = model_hazard();
        if (fl || hz) begin
            m_valid = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0;
            m_rs = 0; m_rt = 0; m_rd = 0; m_ctrl = 0; m_funct = 0;
        end else begin
            m_valid   = m_ifid_valid;
            m_rs      = ins[25:21];
            m_rt      = ins[20:16];
            m_rd      = dest_of(ins);
            m_rs_data = mread(ins[25:21], we, wa, wd);
            m_rt_data = mread(ins[20:16], we, wa, wd);
            m_imm     = {{16{ins[15]}}, ins[15:0]};
            m_ctrl    = ctrl_of(ins[31:26]);
            m_funct   = ins[5:0];
            if (ins[31:26] == 6'h04)      m_ex_add = m_ifid_pc4 + m_imm * 4;
            else if (ins[31:26] == 6'h02) m_ex_add = {m_ifid_pc4[31:28], ins[25:0], 2'b00};
            else                          m_ex_add = m_ifid_pc4;
        end
        if (we && wa != 0) m_regs[wa] = wd;
        if (fl) begin
            m_ifid_instr = 32'd0; m_ifid_valid = 0;
        end else if (!hz) begin
            m_ifid_instr = in_i; m_ifid_pc4 = in_pc4; m_ifid_valid = 1;
        end
    endtask

    task automatic check_all();
        check("hazard", {31'd0, hazard}, {31'd0, model_hazard()});
        check("ex_add", ex_add, m_ex_add);
        check("valid", {31'd0, id_ex_valid}, {31'd0, m_valid});
        check("rs_data", id_ex_rs_data, m_rs_data);
        check("rt_data", id_ex_rt_data, m_rt_data);
        check("imm", id_ex_imm, m_imm);
        check("rs", {27'd0, id_ex_rs}, {27'd0, m_rs});
        check("rt", {27'd0, id_ex_rt}, {27'd0, m_rt});
        check("rd", {27'd0, id_ex_rd}, {27'd0, m_rd});
        check("ctrl", {24'd0, id_ex_ctrl}, {24'd0, m_ctrl});
        check("funct", {26'd0, id_ex_funct}, {26'd0, m_funct});
    endtask

    // Drive one cycle's inputs, compare the current state, then advance DUT and model together
    task automatic cycle(input logic [31:0] in_i, input logic [31:0] in_pc4, input logic fl,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        instruction = in_i; pc4 = in_pc4; flush = fl;
        wb_we = we; wb_addr = wa; wb_data = wd;
        #1;
        check_all();
        @(posedge clk);
        model_step(in_i, in_pc4, fl, we, wa, wd);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        case ($urandom_range(0, 6))
            0: op = 6'h00;
            1: op = 6'h23;
            2: op = 6'h2b;
            3: op = 6'h04;
            4: op = 6'h08;
            5: op = 6'h02;
            default: op = 6'($urandom);
        endcase
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 11'($urandom)};
    endfunction

    initial begin
        model_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            instruction = $urandom; pc4 = $urandom; flush = 1'($urandom);
            wb_we = 1'b1; wb_addr = 5'($urandom); wb_data = $urandom;
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
        rst = 1'b0;

        // Every register reads zero after reset
        for (int i = 1; i < 32; i++)
            cycle(rtype(5'(i), 5'(i), 5'd1, 6'h20), 32'h4 * i, 0, 0, 0, 0);

        // Writeback bypass and r0
        cycle(rtype(5'd5, 5'd0, 5'd3, 6'h20), 32'h40, 0, 0, 0, 0);
        cycle(32'd0, 32'h44, 0, 1, 5'd5, 32'hDEAD_BEEF);
        check("bypass_rs", id_ex_rs_data, 32'hDEAD_BEEF);
        cycle(rtype(5'd0, 5'd0, 5'd3, 6'h20), 32'h48, 0, 1, 5'd0, 32'h1234_5678);
        cycle(32'd0, 32'h4c, 0, 0, 0, 0);
        check("r0_zero", id_ex_rs_data, 32'd0);

        // Load-use: one-cycle stall, bubble, then the dependant issues
        cycle(itype(6'h23, 5'd1, 5'd2, 16'd0), 32'h50, 0, 0, 0, 0);
        cycle(rtype(5'd2, 5'd3, 5'd4, 6'h20), 32'h54, 0, 0, 0, 0);
        check("lu_hazard", {31'd0, hazard}, 32'd1);
        cycle(rtype(5'd2, 5'd3, 5'd4, 6'h20), 32'h54, 0, 0, 0, 0);
        check("lu_one_cycle", {31'd0, hazard}, 32'd0);
        check("lu_bubble", {31'd0, id_ex_valid}, 32'd0);
        cycle(32'd0, 32'h58, 0, 0, 0, 0);
        check("lu_issue_valid", {31'd0, id_ex_valid}, 32'd1);
        check("lu_issue_rd", {27'd0, id_ex_rd}, 32'd4);
        cycle(itype(6'h23, 5'd1, 5'd2, 16'd0), 32'h5c, 0, 0, 0, 0);
        cycle(itype(6'h08, 5'd9, 5'd2, 16'd5), 32'h60, 0, 0, 0, 0);
        check("addi_no_stall", {31'd0, hazard}, 32'd0);

        // Branch and jump targets
        cycle(itype(6'h04, 5'd1, 5'd1, 16'hFFFE), 32'h100, 0, 0, 0, 0);
        cycle({6'h02, 26'h40}, 32'h1000_0004, 0, 0, 0, 0);
        check("beq_target", ex_add, 32'h0000_00F8);
        cycle(32'd0, 32'h1000_0008, 0, 0, 0, 0);
        check("j_target", ex_add, 32'h1000_0100);

        // Flush wins over a pending hazard
        cycle(itype(6'h23, 5'd1, 5'd2, 16'd0), 32'h200, 0, 0, 0, 0);
        cycle(rtype(5'd2, 5'd3, 5'd4, 6'h20), 32'h204, 0, 0, 0, 0);
        check("fl_hazard_pre", {31'd0, hazard}, 32'd1);
        cycle(rtype(5'd2, 5'd3, 5'd4, 6'h20), 32'h204, 1, 0, 0, 0);
        check("fl_hazard_post", {31'd0, hazard}, 32'd0);
        check("fl_valid", {31'd0, id_ex_valid}, 32'd0);
        cycle(32'd0, 32'h208, 0, 0, 0, 0);
        check("fl_nop_valid", {31'd0, id_ex_valid}, 32'd0);
        check("fl_nop_rd", {27'd0, id_ex_rd}, 32'd0);

        // Asynchronous reset in the middle of a stall
        cycle(itype(6'h23, 5'd1, 5'd2, 16'd0), 32'h300, 0, 0, 0, 0);
        cycle(rtype(5'd2, 5'd2, 5'd4, 6'h20), 32'h304, 0, 0, 0, 0);
        check("ar_hazard_pre", {31'd0, hazard}, 32'd1);
        rst = 1'b1;
        #2;
        check("ar_hazard", {31'd0, hazard}, 32'd0);
        check("ar_valid", {31'd0, id_ex_valid}, 32'd0);
        check("ar_ctrl", {24'd0, id_ex_ctrl}, 32'd0);
        check("ar_ex_add", ex_add, 32'd0);
        model_reset();
        rst = 1'b0;
        cycle(itype(6'h23, 5'd9, 5'd8, 16'd4), 32'h400, 0, 0, 0, 0);
        cycle(32'd0, 32'h404, 0, 0, 0, 0);
        check("ar_lw_ctrl", {24'd0, id_ex_ctrl}, 32'h0000_00D0);
        check("ar_lw_valid", {31'd0, id_ex_valid}, 32'd1);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++)
            cycle(rand_instr(), $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 7) == 0),
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
